// File: rtl/exec_unit_mc.sv
// exec_unit_mc: multi-cycle EX-stage execution unit for the SimpleRisc ALU op set.
// Operand B is taken from op2 or immx, captured together with op1 on accept.
// Single-cycle ops load a registered result on the accept edge; MUL runs a
// shift-add loop and DIV/MOD a restoring divider on magnitudes followed by a
// sign fix-up cycle. Valid/ready handshakes on both sides stall the pipeline.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        upstream handshake
//   op1, op2, immx             operand A, register operand B, immediate
//   isImmediate                1 selects immx as operand B
//   aluSignals                 4-bit opcode (13-15 illegal)
//   out_valid / out_ready      downstream handshake
//   aluResult                  registered result
//   div_zero, illegal_op       qualifiers of the current result
//   flag_e, flag_gt            flags of the last CMP (equal, signed greater)
//   busy                       iterative op in progress
module exec_unit_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [WIDTH-1:0] immx,
    input  logic             isImmediate,
    input  logic [3:0]       aluSignals,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] aluResult,
    output logic             div_zero,
    output logic             illegal_op,
    output logic             flag_e,
    output logic             flag_gt,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2,  OP_DIV = 4'd3,  OP_MOD = 4'd4,
        OP_CMP = 4'd5, OP_AND = 4'd6, OP_OR  = 4'd7,  OP_NOT = 4'd8,  OP_MOV = 4'd9,
        OP_LSL = 4'd10, OP_LSR = 4'd11, OP_ASR = 4'd12
    } op_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] x_q, x_d;       // MUL multiplicand / DIV dividend-quotient shifter
    logic [WIDTH-1:0] y_q, y_d;       // MUL multiplier / DIV divisor magnitude
    logic [WIDTH-1:0] acc_q, acc_d;   // MUL accumulator / DIV partial remainder
    logic [WIDTH-1:0] a_q, a_d;       // original A, returned as remainder on B==0
    logic             neg_q_q, neg_q_d, neg_r_q, neg_r_d, bzero_q, bzero_d, is_mod_q, is_mod_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             div_zero_q, div_zero_d, illegal_q, illegal_d;
    logic             flag_e_q, flag_e_d, flag_gt_q, flag_gt_d;

    logic             accept, ld, ld_dz, ld_ill;
    logic [WIDTH-1:0] b_mux, ld_val, mul_acc, quo, rem;
    logic [WIDTH:0]   rem_sh;
    logic [SHW-1:0]   shamt;

    // NOTE: every signal driven here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        acc_d       = acc_q;
        a_d         = a_q;
        neg_q_d     = neg_q_q;
        neg_r_d     = neg_r_q;
        bzero_d     = bzero_q;
        is_mod_d    = is_mod_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        div_zero_d  = div_zero_q;
        illegal_d   = illegal_q;
        flag_e_d    = flag_e_q;
        flag_gt_d   = flag_gt_q;
        ld          = 1'b0;
        ld_val      = '0;
        ld_dz       = 1'b0;
        ld_ill      = 1'b0;
        mul_acc     = '0;
        rem_sh      = '0;
        quo         = '0;
        rem         = '0;

        in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
        accept   = in_valid && in_ready;
        b_mux    = isImmediate ? immx : op2;
        shamt    = b_mux[SHW-1:0];

        // Consumption first; a load in the same cycle overrides it below.
        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (op_e'(aluSignals))
                        OP_ADD: begin ld = 1'b1; ld_val = op1 + b_mux; end
                        OP_SUB: begin ld = 1'b1; ld_val = op1 - b_mux; end
                        OP_CMP: begin
                            ld        = 1'b1;
                            flag_e_d  = (op1 == b_mux);
                            flag_gt_d = ($signed(op1) > $signed(b_mux));
                        end
                        OP_AND: begin ld = 1'b1; ld_val = op1 & b_mux; end
                        OP_OR:  begin ld = 1'b1; ld_val = op1 | b_mux; end
                        OP_NOT: begin ld = 1'b1; ld_val = ~b_mux; end
                        OP_MOV: begin ld = 1'b1; ld_val = b_mux; end
                        OP_LSL: begin ld = 1'b1; ld_val = op1 << shamt; end
                        OP_LSR: begin ld = 1'b1; ld_val = op1 >> shamt; end
                        OP_ASR: begin ld = 1'b1; ld_val = $signed(op1) >>> shamt; end
                        OP_MUL: begin
                            // Low WIDTH bits of a signed product equal those of the
                            // unsigned product of the same bit patterns.
                            state_d = S_MUL;
                            cnt_d   = '1;
                            x_d     = op1;
                            y_d     = b_mux;
                            acc_d   = '0;
                        end
                        OP_DIV, OP_MOD: begin
                            state_d  = S_DIV;
                            cnt_d    = '1;
                            x_d      = op1[WIDTH-1] ? -op1 : op1;
                            y_d      = b_mux[WIDTH-1] ? -b_mux : b_mux;
                            acc_d    = '0;
                            a_d      = op1;
                            neg_q_d  = op1[WIDTH-1] ^ b_mux[WIDTH-1];
                            neg_r_d  = op1[WIDTH-1];
                            bzero_d  = (b_mux == '0);
                            is_mod_d = (aluSignals == OP_MOD);
                        end
                        default: begin ld = 1'b1; ld_ill = 1'b1; end
                    endcase
                end
            end
            S_MUL: begin
                mul_acc = acc_q + (y_q[0] ? x_q : '0);
                acc_d   = mul_acc;
                x_d     = x_q << 1;
                y_d     = y_q >> 1;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    ld      = 1'b1;
                    ld_val  = mul_acc;
                end
            end
            S_DIV: begin
                // Restoring step: shift the next dividend bit into the remainder and
                // subtract the divisor when it fits, recording a quotient 1.
                rem_sh = {acc_q, x_q[WIDTH-1]};
                x_d    = x_q << 1;
                if (rem_sh >= {1'b0, y_q}) begin
                    rem_sh = rem_sh - {1'b0, y_q};
                    x_d[0] = 1'b1;
                end
                acc_d = rem_sh[WIDTH-1:0];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) state_d = S_FIX;
            end
            S_FIX: begin
                quo     = bzero_q ? '1  : (neg_q_q ? -x_q : x_q);
                rem     = bzero_q ? a_q : (neg_r_q ? -acc_q : acc_q);
                state_d = S_IDLE;
                ld      = 1'b1;
                ld_val  = is_mod_q ? rem : quo;
                ld_dz   = bzero_q;
            end
            default: state_d = S_IDLE;
        endcase

        if (ld) begin
            out_valid_d = 1'b1;
            result_d    = ld_val;
            div_zero_d  = ld_dz;
            illegal_d   = ld_ill;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its next-state value from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: only control and visible outputs are reset; the datapath
            // work registers are don't-care until a new op loads them.
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            div_zero_q  <= 1'b0;
            illegal_q   <= 1'b0;
            flag_e_q    <= 1'b0;
            flag_gt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            div_zero_q  <= div_zero_d;
            illegal_q   <= illegal_d;
            flag_e_q    <= flag_e_d;
            flag_gt_q   <= flag_gt_d;
        end
    end

    always_ff @(posedge clk) begin
        cnt_q    <= cnt_d;
        x_q      <= x_d;
        y_q      <= y_d;
        acc_q    <= acc_d;
        a_q      <= a_d;
        neg_q_q  <= neg_q_d;
        neg_r_q  <= neg_r_d;
        bzero_q  <= bzero_d;
        is_mod_q <= is_mod_d;
    end

    assign out_valid  = out_valid_q;
    assign aluResult  = result_q;
    assign div_zero   = div_zero_q;
    assign illegal_op = illegal_q;
    assign flag_e     = flag_e_q;
    assign flag_gt    = flag_gt_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_exec_unit_mc.sv
// Directed bench for exec_unit_mc (WIDTH=32): expected values hand-computed.
module tb_exec_unit_mc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] op1 = '0, op2 = '0, immx = '0;
    logic        isImmediate = 1'b0;
    logic [3:0]  aluSignals = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] aluResult;
    logic        div_zero, illegal_op, flag_e, flag_gt, busy;

    int vectors = 0;
    int miscompares = 0;

    exec_unit_mc #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .immx(immx), .isImmediate(isImmediate),
        .aluSignals(aluSignals),
        .out_valid(out_valid), .out_ready(out_ready),
        .aluResult(aluResult), .div_zero(div_zero), .illegal_op(illegal_op),
        .flag_e(flag_e), .flag_gt(flag_gt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one op, checks it is accepted at the next edge, then waits (bounded)
    // for out_valid. lat counts edges from the accept edge (which counts as 1).
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] imm, input logic isimm,
                          output logic [31:0] res, output int lat,
                          output logic busy_all, output logic rdy_any);
        op1 = a; op2 = b; immx = imm; isImmediate = isimm; aluSignals = op;
        in_valid = 1'b1; out_ready = 1'b1;
        check({tag, "_accept"}, {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1; busy_all = 1'b1; rdy_any = 1'b0;
        while (!out_valid && lat < 200) begin
            busy_all &= busy;
            rdy_any  |= in_ready;
            @(posedge clk); #1;
            lat++;
        end
        res = aluResult;
    endtask

    logic [31:0] res, hold;
    int          lat;
    logic        ba, ra, any_v, stable, rdy_seen;

    initial begin
        // Reset state
        #2;
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result", aluResult, 32'd0);
        check("rst_flags", {28'b0, div_zero, illegal_op, flag_e, flag_gt}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // ADD, register and immediate paths
        run_op("add_reg", 4'd0, 32'd5, 32'd7, 32'd0, 1'b0, res, lat, ba, ra);
        check("add_reg_res", res, 32'd12);
        check("add_reg_lat", 32'(lat), 32'd1);
        run_op("add_imm", 4'd0, 32'd5, 32'd7, 32'hFFFF_FFFF, 1'b1, res, lat, ba, ra);
        check("add_imm_res", res, 32'd4);

        // MUL -3 * 7
        run_op("mul", 4'd2, 32'hFFFF_FFFD, 32'd7, 32'd0, 1'b0, res, lat, ba, ra);
        check("mul_res", res, 32'hFFFF_FFEB);
        check("mul_lat", 32'(lat), 32'd33);
        check("mul_busy", {31'b0, ba}, 32'd1);
        check("mul_inrdy", {31'b0, ra}, 32'd0);

        // DIV / MOD -7 / 2
        run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0, res, lat, ba, ra);
        check("div_res", res, 32'hFFFF_FFFD);
        check("div_lat", 32'(lat), 32'd34);
        check("div_busy", {31'b0, ba}, 32'd1);
        run_op("mod", 4'd4, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0, res, lat, ba, ra);
        check("mod_res", res, 32'hFFFF_FFFF);
        check("mod_dz", {31'b0, div_zero}, 32'd0);

        // Divide by zero and overflow
        run_op("div0", 4'd3, 32'd9, 32'd0, 32'd0, 1'b0, res, lat, ba, ra);
        check("div0_res", res, 32'hFFFF_FFFF);
        check("div0_dz", {31'b0, div_zero}, 32'd1);
        check("div0_lat", 32'(lat), 32'd34);
        run_op("mod0", 4'd4, 32'd9, 32'd0, 32'd0, 1'b0, res, lat, ba, ra);
        check("mod0_res", res, 32'd9);
        check("mod0_dz", {31'b0, div_zero}, 32'd1);
        run_op("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, res, lat, ba, ra);
        check("divovf_res", res, 32'h8000_0000);
        check("divovf_dz", {31'b0, div_zero}, 32'd0);

        // Backpressure: ADD result held for 5 clocks
        run_op("bp_add", 4'd0, 32'd100, 32'd23, 32'd0, 1'b0, res, lat, ba, ra);
        out_ready = 1'b0;
        hold = aluResult; stable = 1'b1; rdy_seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            stable   &= (aluResult === hold) && out_valid;
            rdy_seen |= in_ready;
        end
        check("bp_hold_res", aluResult, 32'd123);
        check("bp_stable", {31'b0, stable}, 32'd1);
        check("bp_inrdy", {31'b0, rdy_seen}, 32'd0);
        // Release: the next ADD is accepted in the same cycle
        op1 = 32'd1; op2 = 32'd1; isImmediate = 1'b0; aluSignals = 4'd0;
        in_valid = 1'b1; out_ready = 1'b1; #1;
        check("bp_release_rdy", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        check("b2b_add", aluResult, 32'd2);
        // Four single-cycle ops at one per clock
        op1 = 32'd10;  op2 = 32'd3;  aluSignals = 4'd1;  @(posedge clk); #1;
        check("b2b_sub", aluResult, 32'd7);
        check("b2b_sub_v", {31'b0, out_valid}, 32'd1);
        op1 = 32'hF0;  op2 = 32'h3C; aluSignals = 4'd6;  @(posedge clk); #1;
        check("b2b_and", aluResult, 32'h30);
        op1 = 32'd1;   op2 = 32'd4;  aluSignals = 4'd10; @(posedge clk); #1;
        check("b2b_lsl", aluResult, 32'h10);
        op1 = 32'd77;  op2 = 32'd0;  aluSignals = 4'd8;  @(posedge clk); #1;
        check("b2b_not", aluResult, 32'hFFFF_FFFF);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("b2b_drain", {31'b0, out_valid}, 32'd0);

        // CMP and flags
        run_op("cmp", 4'd5, 32'd3, 32'hFFFF_FFFF, 32'd0, 1'b0, res, lat, ba, ra);
        check("cmp_res", res, 32'd0);
        check("cmp_flags", {30'b0, flag_e, flag_gt}, 32'd1);
        run_op("cmp_add", 4'd0, 32'd8, 32'd8, 32'd0, 1'b0, res, lat, ba, ra);
        check("flags_kept", {30'b0, flag_e, flag_gt}, 32'd1);
        run_op("cmp_eq", 4'd5, 32'd8, 32'd0, 32'd8, 1'b1, res, lat, ba, ra);
        check("cmp_eq_flags", {30'b0, flag_e, flag_gt}, 32'd2);

        // Shifts
        run_op("asr", 4'd12, 32'h8000_0000, 32'h21, 32'd0, 1'b0, res, lat, ba, ra);
        check("asr_res", res, 32'hC000_0000);
        run_op("lsr", 4'd11, 32'h8000_0000, 32'h21, 32'd0, 1'b0, res, lat, ba, ra);
        check("lsr_res", res, 32'h4000_0000);

        // Illegal opcode
        run_op("ill", 4'd14, 32'd5, 32'd6, 32'd0, 1'b0, res, lat, ba, ra);
        check("ill_res", res, 32'd0);
        check("ill_flag", {31'b0, illegal_op}, 32'd1);
        check("ill_lat", 32'(lat), 32'd1);
        run_op("mov", 4'd9, 32'd5, 32'd6, 32'd0, 1'b0, res, lat, ba, ra);
        check("mov_res", res, 32'd6);
        check("mov_ill_clr", {31'b0, illegal_op}, 32'd0);

        // Reset mid-DIV (cycle 10); flags were set by the last CMP
        op1 = 32'd100; op2 = 32'd7; isImmediate = 1'b0; aluSignals = 4'd3;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_result", aluResult, 32'd0);
        check("mid_rst_flags", {28'b0, div_zero, illegal_op, flag_e, flag_gt}, 32'd0);
        #3 rst_n = 1'b1;
        any_v = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            any_v |= out_valid | busy;
        end
        check("no_stale", {31'b0, any_v}, 32'd0);
        run_op("post_rst_add", 4'd0, 32'd20, 32'd22, 32'd0, 1'b0, res, lat, ba, ra);
        check("post_rst_res", res, 32'd42);
        check("post_rst_lat", 32'(lat), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/exec_unit_mc.md
Name: exec_unit_mc

Overview:
- Parametrised, multi-cycle successor to the single-cycle ALU wrapper.
- Selects operand B from register or immediate, then executes the SimpleRisc ALU op set.
  - Single-cycle ops return a registered result.
  - MUL, DIV and MOD run iteratively.
- Sits in the EX stage between operand fetch and memory/writeback.
- Uses a valid/ready handshake on both sides, so the pipeline stalls on long ops.
- Holds the CMP flags register (E, GT).

Parameters:
- WIDTH, 32, datapath width in bits; must be at least 8 and a power of two.
- SHW, $clog2(WIDTH), shift-amount bits taken from operand B.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream has an op.
- in_ready  out  1  unit accepts an op this cycle.
- op1  in  WIDTH  operand A.
- op2  in  WIDTH  register operand B.
- immx  in  WIDTH  sign/zero-extended immediate.
- isImmediate  in  1  1 selects immx as B; 0 selects op2.
- aluSignals  in  4  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5 CMP, 6 AND, 7 OR, 8 NOT, 9 MOV, 10 LSL, 11 LSR, 12 ASR; 13-15 illegal.
- out_valid  out  1  aluResult is valid.
- out_ready  in  1  downstream consumes the result.
- aluResult  out  WIDTH  registered result.
- div_zero  out  1  qualifies the current result: DIV/MOD with B==0.
- illegal_op  out  1  qualifies the current result: opcode 13-15.
- flag_e  out  1  last CMP: A==B.
- flag_gt  out  1  last CMP: signed A>B.
- busy  out  1  iterative op in progress.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE.
  - out_valid, aluResult, div_zero, illegal_op, flag_e, flag_gt and busy all 0.
  - An in-flight iterative op is discarded; no partial result is ever presented.
- Acceptance and operand capture:
  - Accept = in_valid & in_ready.
  - in_ready = (state==IDLE) & (!out_valid | out_ready).
  - A and the muxed B are captured at accept; later input changes are ignored.
- States:
  - IDLE: accepting. A single-cycle op goes to RESP with its result loaded. MUL goes to MUL. DIV/MOD go to DIV.
  - MUL: shift-add, one bit per cycle, WIDTH cycles, then RESP.
  - DIV: restoring division on magnitudes, WIDTH cycles, then FIX.
  - FIX: applies signs, 1 cycle, then RESP.
  - RESP: not a wait state. The result register is loaded and out_valid=1; control is back in IDLE. The output register holds until out_ready.
- Latency, accept edge to out_valid high:
  - Single-cycle ops: 1 clock.
  - MUL: WIDTH+1 clocks.
  - DIV/MOD: WIDTH+2 clocks.
  - busy=1 in the MUL, DIV and FIX states.
- Back-to-back:
  - When out_valid & out_ready, a new accept is allowed in the same cycle.
  - A single-cycle op can therefore sustain 1 op/clock.
- Output hold:
  - When out_valid & !out_ready, aluResult and the qualifiers stay stable.
  - in_ready=0 in that case.
- Arithmetic (all modulo 2^WIDTH):
  - ADD/SUB wrap. MUL returns the low WIDTH bits of the signed product.
  - DIV: signed quotient, truncated toward zero. MOD: remainder carrying the sign of A.
  - MIN_INT / -1 gives MIN_INT for DIV and 0 for MOD.
  - B==0 gives quotient all-ones and remainder = A; div_zero=1. DIV/MOD still take the full latency.
  - NOT/MOV ignore A and use B.
  - LSL/LSR/ASR shift A by B[SHW-1:0]; the upper bits of B are ignored.
- CMP:
  - aluResult=0.
  - flag_e and flag_gt update at the edge where the CMP result is loaded.
  - No other op changes the flags.
- Illegal opcode: aluResult=0, illegal_op=1, latency 1.

Test Plan:
- ADD, reg path: op1=5, op2=7, isImm=0 -> out_valid 1 clock after accept, result 12. Same op with isImm=1, immx=0xFFFFFFFF -> result 4.
- MUL/DIV/MOD signed, WIDTH=32:
  - MUL -3 × 7 -> 0xFFFFFFEB at exactly 33 clocks after accept; in_ready=0 and busy=1 throughout.
  - DIV -7/2 -> 0xFFFFFFFD at 34 clocks.
  - MOD -7/2 -> 0xFFFFFFFF.
- Divide by zero: DIV 9/0 -> result 0xFFFFFFFF, div_zero=1. MOD 9/0 -> result 9, div_zero=1. DIV 0x80000000/-1 -> 0x80000000, div_zero=0.
- Backpressure: hold out_ready=0 for 5 clocks after ADD completes -> result stable, in_ready=0. Release -> next ADD is accepted the same cycle, and 4 single-cycle ops then run at 1/clk.
- CMP and shifts:
  - CMP 3 vs -1 -> flag_gt=1, flag_e=0; flags are unchanged by a following ADD.
  - ASR 0x80000000 by B=0x21 (shift 1) -> 0xC0000000.
  - Opcode 14 -> illegal_op=1, result 0.
- Reset mid-op: assert rst_n=0 during cycle 10 of a DIV -> all outputs 0 asynchronously. After release, an ADD completes normally with no stale result.
